// File: rtl/pipe_hazard_pkg.sv
// Shared types for pipe_hazard_unit: shadow-slot record, stage index names and the zero register.
// SLOT_AW / SLOT_NSRC fix the slot layout and must equal the unit's REG_AW / NUM_SRC.
package pipe_hazard_pkg;

  localparam int SLOT_AW   = 4;
  localparam int SLOT_NSRC = 2;

  localparam logic [SLOT_AW-1:0] ZERO_REG = '0;

  typedef enum logic [1:0] {
    EX  = 2'd0,
    MEM = 2'd1,
    WB  = 2'd2
  } stage_e;

  typedef struct packed {
    logic                                valid;
    logic [SLOT_AW-1:0]                  dst;
    logic                                reg_write;
    logic                                is_load;
    logic                                is_store;
    logic [SLOT_NSRC-1:0][SLOT_AW-1:0]   src;
    logic [SLOT_NSRC-1:0]                src_en;
  } slot_t;

endpackage

// File: rtl/pipe_hazard_unit_if.sv
// Decode/forwarding bundle between the pipeline registers and pipe_hazard_unit.
// Memory-to-memory signals exist only with PIPE_HAZARD_MEM2MEM_EN defined.
interface pipe_hazard_unit_if #(
  parameter int DATA_W  = 16,
  parameter int REG_AW  = 4,
  parameter int NUM_SRC = 2,
  parameter int DEPTH   = 3
);
  localparam int SW = $clog2(DEPTH);

  logic                        id_valid;
  logic [NUM_SRC*REG_AW-1:0]   id_src_addr;
  logic [NUM_SRC-1:0]          id_src_en;
  logic [REG_AW-1:0]           id_dst_addr;
  logic                        id_reg_write;
  logic                        id_is_load;
  logic                        id_is_store;
  logic                        flush;
  logic [(DEPTH-1)*DATA_W-1:0] stage_data;

  logic                        stall;
  logic [NUM_SRC-1:0]          ex_fwd_hit;
  logic [NUM_SRC*DATA_W-1:0]   ex_fwd_data;
  logic [NUM_SRC*SW-1:0]       ex_fwd_stage;
  logic [15:0]                 stall_cnt;
`ifdef PIPE_HAZARD_MEM2MEM_EN
  logic                        mem_fwd_hit;
  logic [DATA_W-1:0]           mem_fwd_data;
`endif

  modport master (
    output id_valid, id_src_addr, id_src_en, id_dst_addr, id_reg_write,
    output id_is_load, id_is_store, flush, stage_data,
`ifdef PIPE_HAZARD_MEM2MEM_EN
    input  mem_fwd_hit, mem_fwd_data,
`endif
    input  stall, ex_fwd_hit, ex_fwd_data, ex_fwd_stage, stall_cnt
  );

  modport slave (
    input  id_valid, id_src_addr, id_src_en, id_dst_addr, id_reg_write,
    input  id_is_load, id_is_store, flush, stage_data,
`ifdef PIPE_HAZARD_MEM2MEM_EN
    output mem_fwd_hit, mem_fwd_data,
`endif
    output stall, ex_fwd_hit, ex_fwd_data, ex_fwd_stage, stall_cnt
  );

endinterface

// File: rtl/pipe_hazard_unit_haz_match.sv
// haz_match: compares one register address against the shadow slots in [FIRST, LAST],
// returning per-slot hit flags and the youngest (lowest-index) hit.
module haz_match
  import pipe_hazard_pkg::*;
#(
  parameter int DEPTH       = 3,
  parameter int FIRST       = 0,
  parameter int LAST        = DEPTH - 1,
  parameter bit LOAD_ONLY   = 1'b0,
  parameter bit ZERO_REG_EN = 1'b1,
  parameter int IW          = $clog2(DEPTH)
) (
  input  logic [SLOT_AW-1:0] addr_i,
  input  logic               en_i,
  input  slot_t              slots_i [DEPTH],
  output logic [DEPTH-1:0]   hit_o,
  output logic               any_o,
  output logic [IW-1:0]      idx_o
);

  logic addr_live;
  assign addr_live = en_i && !(ZERO_REG_EN && (addr_i == ZERO_REG));

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_slot
      if (gi >= FIRST && gi <= LAST) begin : g_in
        assign hit_o[gi] = addr_live && slots_i[gi].valid && slots_i[gi].reg_write
                           && (slots_i[gi].dst == addr_i)
                           && (!LOAD_ONLY || slots_i[gi].is_load);
      end else begin : g_out
        assign hit_o[gi] = 1'b0;
      end
    end
  endgenerate

  // Scan oldest to youngest so the lowest-index hit is the one left standing.
  always_comb begin
    any_o = 1'b0;
    idx_o = '0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      if (hit_o[k]) begin
        any_o = 1'b1;
        idx_o = IW'(k);
      end
    end
  end

endmodule

// File: rtl/pipe_hazard_unit.sv
// Hazard detection and EX forwarding from a shadow pipeline of destination tags (slot 0 = EX).
// Optional PIPE_HAZARD_MEM2MEM_EN adds load-to-store forwarding into MEM and waives that stall.
module pipe_hazard_unit
  import pipe_hazard_pkg::*;
#(
  parameter int DATA_W      = 16,
  parameter int REG_AW      = 4,
  parameter int NUM_SRC     = 2,
  parameter int DEPTH       = 3,
  parameter int LOAD_STAGE  = 2,
  parameter int STORE_SRC   = 1,
  parameter int ZERO_REG_EN = 1
) (
  input  logic               clk,
  input  logic               rst,
  pipe_hazard_unit_if.slave  bus
);

  localparam int SW = $clog2(DEPTH);

  slot_t                         slot_q [DEPTH];
  slot_t                         slot0_d;
  logic [15:0]                   stall_cnt_q;
  logic [15:0]                   stall_cnt_d;
  logic                          stall;
  logic                          haz;

  logic [NUM_SRC-1:0][DEPTH-1:0] id_haz;
  logic [NUM_SRC-1:0]            id_haz_any;
  logic [NUM_SRC-1:0]            ex_any;
  logic [NUM_SRC-1:0][SW-1:0]    ex_idx;
  logic [NUM_SRC-1:0]            ex_hit;
  logic [NUM_SRC*DATA_W-1:0]     ex_data;
  logic [NUM_SRC*SW-1:0]         ex_stage;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_SRC; gi++) begin : g_src
      logic [SW-1:0]    id_idx_unused;
      logic [DEPTH-1:0] ex_hits_unused;

      haz_match #(
        .DEPTH(DEPTH), .FIRST(0), .LAST(LOAD_STAGE - 2),
        .LOAD_ONLY(1'b1), .ZERO_REG_EN(ZERO_REG_EN != 0)
      ) u_id (
        .addr_i  (bus.id_src_addr[gi*REG_AW +: REG_AW]),
        .en_i    (bus.id_src_en[gi]),
        .slots_i (slot_q),
        .hit_o   (id_haz[gi]),
        .any_o   (id_haz_any[gi]),
        .idx_o   (id_idx_unused)
      );

      haz_match #(
        .DEPTH(DEPTH), .FIRST(1), .LAST(DEPTH - 1),
        .LOAD_ONLY(1'b0), .ZERO_REG_EN(ZERO_REG_EN != 0)
      ) u_ex (
        .addr_i  (slot_q[0].src[gi]),
        .en_i    (slot_q[0].valid & slot_q[0].src_en[gi]),
        .slots_i (slot_q),
        .hit_o   (ex_hits_unused),
        .any_o   (ex_any[gi]),
        .idx_o   (ex_idx[gi])
      );
    end
  endgenerate

  always_comb begin
    haz = |id_haz_any;
`ifdef PIPE_HAZARD_MEM2MEM_EN
    // A store's data operand fed by the load just ahead is picked up in MEM instead.
    if (bus.id_is_store) begin
      haz = 1'b0;
      for (int s = 0; s < NUM_SRC; s++) begin
        if (s == STORE_SRC) haz = haz | (|id_haz[s][DEPTH-1:1]);
        else                haz = haz | id_haz_any[s];
      end
    end
`endif
  end

  assign stall = bus.id_valid & ~bus.flush & haz;

  always_comb begin
    slot0_d = '0;
    if (bus.id_valid && !stall && !bus.flush) begin
      slot0_d.valid     = 1'b1;
      slot0_d.dst       = bus.id_dst_addr;
      slot0_d.reg_write = bus.id_reg_write;
      slot0_d.is_load   = bus.id_is_load;
      slot0_d.is_store  = bus.id_is_store;
      slot0_d.src       = bus.id_src_addr;
      slot0_d.src_en    = bus.id_src_en;
    end
  end

  assign stall_cnt_d = (stall && stall_cnt_q != 16'hFFFF) ? stall_cnt_q + 16'd1 : stall_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < DEPTH; k++) slot_q[k] <= '0;
      stall_cnt_q <= '0;
    end else begin
      slot_q[0] <= slot0_d;
      for (int k = 1; k < DEPTH; k++) slot_q[k] <= slot_q[k-1];
      stall_cnt_q <= stall_cnt_d;
    end
  end

  // A youngest producer that is a load without data yet blocks the forward; older ones would be stale.
  always_comb begin
    ex_hit   = '0;
    ex_data  = '0;
    ex_stage = '0;
    for (int s = 0; s < NUM_SRC; s++) begin
      if (ex_any[s] && !(slot_q[ex_idx[s]].is_load && (int'(ex_idx[s]) < LOAD_STAGE))) begin
        ex_hit[s]                   = 1'b1;
        ex_stage[s*SW +: SW]        = ex_idx[s];
        ex_data[s*DATA_W +: DATA_W] = bus.stage_data[(int'(ex_idx[s]) - 1)*DATA_W +: DATA_W];
      end
    end
  end

  assign bus.stall        = stall;
  assign bus.ex_fwd_hit   = ex_hit;
  assign bus.ex_fwd_data  = ex_data;
  assign bus.ex_fwd_stage = ex_stage;
  assign bus.stall_cnt    = stall_cnt_q;

`ifdef PIPE_HAZARD_MEM2MEM_EN
  logic [DEPTH-1:0] mem_hits_unused;
  logic             mem_any;
  logic [SW-1:0]    mem_idx;
  logic             mem_hit;

  haz_match #(
    .DEPTH(DEPTH), .FIRST(2), .LAST(DEPTH - 1),
    .LOAD_ONLY(1'b0), .ZERO_REG_EN(ZERO_REG_EN != 0)
  ) u_mem (
    .addr_i  (slot_q[1].src[STORE_SRC]),
    .en_i    (slot_q[1].valid & slot_q[1].is_store & slot_q[1].src_en[STORE_SRC]),
    .slots_i (slot_q),
    .hit_o   (mem_hits_unused),
    .any_o   (mem_any),
    .idx_o   (mem_idx)
  );

  assign mem_hit          = mem_any && (int'(mem_idx) == DEPTH - 1);
  assign bus.mem_fwd_hit  = mem_hit;
  assign bus.mem_fwd_data = mem_hit ? bus.stage_data[(DEPTH-2)*DATA_W +: DATA_W] : '0;
`endif

endmodule
